// File: rtl/arb_pkg.sv
// Shared definitions for the job_arbiter slice: FSM state encoding, index-width
// helper and the default watchdog limit.
package arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_START,
    ST_WAIT,
    ST_RELEASE
  } arb_state_t;

  localparam int TIMEOUT_DEFAULT = 64;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/job_arbiter_if.sv
// Requester / datapath-controller bundle seen by job_arbiter.
// master = requesters and controller side, slave = the arbiter itself.
interface job_arbiter_if #(
  parameter int NREQ = 4
);
  import arb_pkg::*;

  localparam int IW = idx_w(NREQ);

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   owner;
  logic            start_out;
  logic            ctl_done;
  logic [NREQ-1:0] done_out;
  logic            busy;
  logic            err;

  modport master (
    output req, ctl_done,
    input  gnt, owner, start_out, done_out, busy, err
  );

  modport slave (
    input  req, ctl_done,
    output gnt, owner, start_out, done_out, busy, err
  );

endinterface

// File: rtl/job_arbiter_rr_picker.sv
// Combinational round-robin picker: lowest set req bit at or after ptr,
// wrapping modulo NREQ.
module rr_picker
  import arb_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IW  = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            valid,
  output logic [IW-1:0]   winner
);

  logic [IW:0] off;
  logic [IW:0] best;

  always_comb begin
    valid  = 1'b0;
    winner = '0;
    off    = '0;
    best   = '0;
    for (int j = 0; j < NREQ; j++) begin
      // distance from ptr to j going upward, modulo NREQ
      off = (IW+1)'(j) - {1'b0, ptr};
      if ((IW+1)'(j) < {1'b0, ptr}) off = off + (IW+1)'(NREQ);
      if (req[j] && (!valid || off < best)) begin
        valid  = 1'b1;
        winner = IW'(j);
        best   = off;
      end
    end
  end

endmodule

// File: rtl/job_arbiter.sv
// Round-robin arbiter/sequencer sharing one iterative datapath among NREQ requesters.
// Optional watchdog in WAIT compiled in with ARB_WATCHDOG_EN.
module job_arbiter
  import arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  job_arbiter_if.slave bus
);

  // state   | meaning
  // IDLE    | no job; arbitrate among pending req
  // GRANT   | owner latched, gnt up, operand mux settles
  // START   | start_out pulse to datapath controller
  // WAIT    | waiting for ctl_done (or watchdog)
  // RELEASE | done_out pulse to owner, ptr advances

  localparam int IW = idx_w(NREQ);

  arb_state_t      state, state_nxt;
  logic [IW-1:0]   ptr, ptr_nxt;
  logic [IW-1:0]   owner, owner_nxt;
  logic [NREQ-1:0] gnt_q, gnt_nxt;
  logic [NREQ-1:0] done_q, done_nxt;
  logic            start_q, start_nxt;
  logic            busy_q, busy_nxt;
  logic            err_q, err_nxt;
  logic            pick_vld;
  logic [IW-1:0]   pick_idx;
  logic            timeout_hit;

  rr_picker #(.NREQ(NREQ)) u_picker (
    .req    (bus.req),
    .ptr    (ptr),
    .valid  (pick_vld),
    .winner (pick_idx)
  );

`ifdef ARB_WATCHDOG_EN
  localparam int CW = ($clog2(TIMEOUT) + 1 > 8) ? $clog2(TIMEOUT) + 1 : 8;
  logic [CW-1:0] wd_cnt;

  // held at zero outside WAIT so it starts from zero on every entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  wd_cnt <= '0;
    else if (state != ST_WAIT) wd_cnt <= '0;
    else                      wd_cnt <= wd_cnt + 1'b1;
  end

  assign timeout_hit = (state == ST_WAIT) && (wd_cnt == CW'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0 && (TIMEOUT > 0);
`endif

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    unique case (state)
      ST_IDLE: begin
        if (pick_vld) begin
          state_nxt = ST_GRANT;
          owner_nxt = pick_idx;
        end
      end
      ST_GRANT:   state_nxt = ST_START;
      ST_START:   state_nxt = ST_WAIT;
      ST_WAIT:    if (bus.ctl_done || timeout_hit) state_nxt = ST_RELEASE;
      ST_RELEASE: begin
        state_nxt = ST_IDLE;
        ptr_nxt   = (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
      end
      default:    state_nxt = ST_IDLE;
    endcase

    gnt_nxt   = (state_nxt != ST_IDLE) ? (NREQ'(1) << owner_nxt) : '0;
    done_nxt  = (state_nxt == ST_RELEASE) ? (NREQ'(1) << owner_nxt) : '0;
    start_nxt = (state_nxt == ST_START);
    busy_nxt  = (state_nxt != ST_IDLE);
    // a done arriving together with the timeout is a normal completion
    err_nxt   = (state == ST_WAIT) && !bus.ctl_done && timeout_hit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      owner   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      owner   <= owner_nxt;
      gnt_q   <= gnt_nxt;
      done_q  <= done_nxt;
      start_q <= start_nxt;
      busy_q  <= busy_nxt;
      err_q   <= err_nxt;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.owner     = owner;
  assign bus.start_out = start_q;
  assign bus.done_out  = done_q;
  assign bus.busy      = busy_q;
  assign bus.err       = err_q;

endmodule
